// File: rtl/data_mem_responder.sv
// data_mem_responder: load/store bus target decoding word RAM, an MMIO bank (LED, cycle counter, scratch) and error space.
// One request at a time, ready pulses WAIT_CYCLES+1 cycles after accept; define DMEM_BYTE_WRITE_EN to add byte strobes.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] MMIO_BASE   = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
`ifdef DMEM_BYTE_WRITE_EN
    input  logic [3:0]  be,
`endif
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic [31:0] led
);
    localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;
    localparam logic [31:0] CNT_ADDR  = MMIO_BASE + 32'd4;
    localparam logic [31:0] SCR_ADDR  = MMIO_BASE + 32'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_wait_cnt;
    logic [3:0]       w_wait_cnt_nxt;
    logic             w_accept;
    logic             w_load_resp;

    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic             r_err;
    logic [31:0]      r_led;
    logic [31:0]      r_scratch;
    logic [31:0]      r_cycle;
    logic [31:0]      r_mem [DEPTH_WORDS];

    logic             w_c_we;
    logic [31:0]      w_c_addr;
    logic [3:0]       w_c_be;
    logic             w_c_full;
    logic             w_c_mis;
    logic             w_c_ram;
    logic             w_c_led;
    logic             w_c_cnt;
    logic             w_c_scr;
    logic [IDX_W-1:0] w_c_idx;
    logic [31:0]      w_resp_rdata;
    logic             w_resp_err;
    logic             w_commit;
    logic             w_ram_we;
    logic             w_led_we;
    logic             w_scr_we;

    // In IDLE the live bus is decoded so a zero-wait response can be formed on the accept edge.
    assign w_c_we   = (r_state == S_IDLE) ? we   : r_we;
    assign w_c_addr = (r_state == S_IDLE) ? addr : r_addr;

`ifdef DMEM_BYTE_WRITE_EN
    logic [3:0] r_be;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_be <= '0;
        end else if (w_accept) begin
            r_be <= be;
        end
    end
    assign w_c_be = (r_state == S_IDLE) ? be : r_be;
`else
    assign w_c_be = 4'hF;
`endif

    assign w_c_full = (w_c_be == 4'hF);
    assign w_c_mis  = |w_c_addr[1:0];
    assign w_c_ram  = (w_c_addr < RAM_BYTES);
    assign w_c_led  = (w_c_addr == MMIO_BASE);
    assign w_c_cnt  = (w_c_addr == CNT_ADDR);
    assign w_c_scr  = (w_c_addr == SCR_ADDR);
    assign w_c_idx  = w_c_addr[IDX_W+1:2];

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_accept       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_accept       = 1'b1;
                    w_wait_cnt_nxt = WAIT_INIT;
                    w_state_nxt    = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                w_wait_cnt_nxt = r_wait_cnt - 4'd1;
                if (r_wait_cnt <= 4'd1) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_load_resp = (w_state_nxt == S_RESP) && (r_state != S_RESP);

    // Counter reads report the value the counter holds during the RESP cycle.
    always_comb begin
        w_resp_rdata = ERR_DATA;
        w_resp_err   = 1'b1;
        if (w_c_mis) begin
            w_resp_rdata = '0;
        end else if (w_c_ram) begin
            w_resp_rdata = r_mem[w_c_idx];
            w_resp_err   = 1'b0;
        end else if (w_c_led) begin
            w_resp_rdata = r_led;
            w_resp_err   = w_c_we && !w_c_full;
        end else if (w_c_cnt) begin
            w_resp_rdata = r_cycle + 32'd1;
            w_resp_err   = w_c_we && !w_c_full;
        end else if (w_c_scr) begin
            w_resp_rdata = r_scratch;
            w_resp_err   = w_c_we && !w_c_full;
        end
    end

    assign w_commit = (r_state == S_RESP) && w_c_we && !w_c_mis;
    assign w_ram_we = w_commit && w_c_ram;
    assign w_led_we = w_commit && !w_c_ram && w_c_led && w_c_full;
    assign w_scr_we = w_commit && !w_c_ram && w_c_scr && w_c_full;

    always_ff @(posedge clk) begin
        if (!rst && w_ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_c_be[b]) begin
                    r_mem[w_c_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_led      <= '0;
            r_scratch  <= '0;
            r_cycle    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_cycle    <= r_cycle + 32'd1;
            if (w_accept) begin
                r_we    <= we;
                r_addr  <= addr;
                r_wdata <= wdata;
            end
            if (w_load_resp) begin
                r_rdata <= w_resp_rdata;
                r_err   <= w_resp_err;
            end
            if (w_led_we) begin
                r_led <= r_wdata;
            end
            if (w_scr_we) begin
                r_scratch <= r_wdata;
            end
        end
    end

    assign ready = (r_state == S_RESP);
    assign rdata = r_rdata;
    assign err   = r_err;
    assign led   = r_led;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: constant vector table, hand-written corner sequences, random traffic against a spec model.
module tb_data_mem_responder;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] MB    = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic [31:0] led;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1), .MMIO_BASE(MB)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
`ifdef DMEM_BYTE_WRITE_EN
        .be    (be),
`endif
        .rdata (rdata),
        .ready (ready),
        .err   (err),
        .led   (led)
    );

    // Reference model state
    logic [31:0] m_mem [int];
    logic [31:0] m_led;
    logic [31:0] m_scr;
    logic [31:0] m_cycle;

    always @(posedge clk) m_cycle <= rst ? 32'd0 : m_cycle + 32'd1;

    typedef enum int { T_RAM, T_LED, T_CNT, T_SCR, T_MIS, T_BAD } tgt_t;

    function automatic tgt_t classify(input logic [31:0] a);
        if (a[1:0] != 2'b00) return T_MIS;
        if (a < 32'(4 * DEPTH)) return T_RAM;
        if (a == MB) return T_LED;
        if (a == MB + 32'd4) return T_CNT;
        if (a == MB + 32'd8) return T_SCR;
        return T_BAD;
    endfunction

    function automatic void model_expect(input logic w, input logic [31:0] a, input logic [3:0] b,
                                         output logic [31:0] e_rd, output logic e_err, output logic e_chk);
        int idx;
        idx   = int'(a >> 2);
        e_rd  = 32'h0;
        e_err = 1'b0;
        e_chk = !w;
        case (classify(a))
            T_MIS: begin e_err = 1'b1; e_rd = 32'h0; e_chk = 1'b1; end
            T_BAD: begin e_err = 1'b1; e_rd = 32'hDEAD_BEEF; e_chk = 1'b1; end
            T_RAM: begin
                e_chk = !w && m_mem.exists(idx);
                if (m_mem.exists(idx)) e_rd = m_mem[idx];
            end
            T_LED: begin e_err = w && (b != 4'hF); e_rd = m_led; end
            T_SCR: begin e_err = w && (b != 4'hF); e_rd = m_scr; end
            T_CNT: begin e_err = w && (b != 4'hF); end
            default: ;
        endcase
    endfunction

    function automatic void model_apply(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        int idx;
        logic [31:0] v;
        idx = int'(a >> 2);
        if (!w) return;
        case (classify(a))
            T_RAM: begin
                if (b == 4'hF) begin
                    m_mem[idx] = d;
                end else if (m_mem.exists(idx)) begin
                    v = m_mem[idx];
                    for (int k = 0; k < 4; k++) if (b[k]) v[8*k +: 8] = d[8*k +: 8];
                    m_mem[idx] = v;
                end
            end
            T_LED: if (b == 4'hF) m_led = d;
            T_SCR: if (b == 4'hF) m_scr = d;
            default: ;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // One handshake from an IDLE cycle; also checks the single-cycle ready pulse and LED update afterwards.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                       output logic [31:0] g_rd, output logic g_err, output int g_lat,
                       output logic [31:0] e_rd, output logic e_err, output logic e_chk);
        logic seen;
        @(posedge clk); #1;
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        model_expect(w, a, be, e_rd, e_err, e_chk);
        seen = 1'b0; g_lat = 0; g_rd = '0; g_err = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (ready) begin
                seen  = 1'b1;
                g_rd  = rdata;
                g_err = err;
            end else begin
                g_lat++;
            end
        end
        req = 1'b0;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL txn_timeout addr=%h got=no_ready exp=ready", a);
        end
        if (classify(a) == T_CNT && !w) e_rd = m_cycle;
        model_apply(w, a, d, be);
        @(negedge clk);
        chk("ready_pulse", 32'(ready), 32'd0);
        chk("led_after", led, m_led);
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic        e_err;
        logic        chk_rd;
        logic [31:0] e_rd;
    } vec_t;

    vec_t        tbl [15];
    logic [31:0] bad_list [4] = '{32'h0000_1000, 32'h0001_000C, 32'hFFFF_FFF0, 32'h0002_0000};

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] g_rd, e_rd, a, d, pat, exp_pat;
        logic        g_err, e_err, e_chk, w, seen;
        logic [3:0]  b;
        int          g_lat, k;

        tbl[0]  = '{1'b1, 32'h0000_0010, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D};
        tbl[2]  = '{1'b1, 32'h0001_0000, 32'h0000_00A5, 1'b0, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 32'h0001_0000, 32'h0,         1'b0, 1'b1, 32'h0000_00A5};
        tbl[4]  = '{1'b1, 32'h0001_0008, 32'h1234_5678, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 32'h0001_0008, 32'h0,         1'b0, 1'b1, 32'h1234_5678};
        tbl[6]  = '{1'b0, 32'h0002_0000, 32'h0,         1'b1, 1'b1, 32'hDEAD_BEEF};
        tbl[7]  = '{1'b1, 32'h0000_0013, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0};
        tbl[8]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D};
        tbl[9]  = '{1'b0, 32'h0000_0012, 32'h0,         1'b1, 1'b1, 32'h0};
        tbl[10] = '{1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 1'b1, 32'h0BAD_F00D};
        tbl[12] = '{1'b0, 32'h0000_1000, 32'h0,         1'b1, 1'b1, 32'hDEAD_BEEF};
        tbl[13] = '{1'b1, 32'h0001_000C, 32'h0000_0001, 1'b1, 1'b1, 32'hDEAD_BEEF};
        tbl[14] = '{1'b1, 32'h0001_0004, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0};

        m_led = '0; m_scr = '0;
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = 4'hF;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_led", led, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        txn(1'b0, MB + 32'd4, 32'h0, 4'hF, g_rd, g_err, g_lat, e_rd, e_err, e_chk);
        chk("cnt_after_reset", g_rd, 32'd3);

        for (int i = 0; i < 15; i++) begin
            txn(tbl[i].w, tbl[i].a, tbl[i].d, 4'hF, g_rd, g_err, g_lat, e_rd, e_err, e_chk);
            chk($sformatf("tbl%0d_err", i), 32'(g_err), 32'(tbl[i].e_err));
            chk($sformatf("tbl%0d_lat", i), 32'(g_lat), 32'd2);
            if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), g_rd, tbl[i].e_rd);
        end
        chk("led_a5", led, 32'h0000_00A5);
        txn(1'b0, MB + 32'd4, 32'h0, 4'hF, g_rd, g_err, g_lat, e_rd, e_err, e_chk);
        chk("cnt_unaffected", g_rd, e_rd);

        // Reset during WAIT of a write: no ready, no commit, back in IDLE.
        txn(1'b1, 32'h20, 32'h5555_AAAA, 4'hF, g_rd, g_err, g_lat, e_rd, e_err, e_chk);
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1234_0000;
        @(negedge clk);
        chk("midrst_c0_ready", 32'(ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; req = 1'b0;
        @(negedge clk);
        chk("midrst_c1_ready", 32'(ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; m_led = '0; m_scr = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_ready", 32'(ready), 32'd0);
        end
        chk("midrst_led", led, 32'd0);
        txn(1'b0, 32'h20, 32'h0, 4'hF, g_rd, g_err, g_lat, e_rd, e_err, e_chk);
        chk("midrst_word8", g_rd, 32'h5555_AAAA);
        chk("midrst_lat", 32'(g_lat), 32'd2);

        // req held high: ready every third cycle, one-cycle pulses.
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = MB + 32'd8;
        pat = '0; exp_pat = '0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            pat[i] = ready;
            if (i % 3 == 2) exp_pat[i] = 1'b1;
        end
        req = 1'b0;
        chk("held_req_pattern", pat, exp_pat);
        repeat (2) @(negedge clk);

        // req dropped during WAIT with a changed address: latched request still completes.
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = 32'h10;
        @(posedge clk); #1;
        req = 1'b0; addr = MB + 32'h0C; we = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (ready) begin
                seen = 1'b1;
                chk("early_drop_rdata", rdata, 32'hCAFE_F00D);
                chk("early_drop_err", 32'(err), 32'd0);
            end
        end
        chk("early_drop_ready", 32'(seen), 32'd1);
        we = 1'b0;
        repeat (2) @(negedge clk);

`ifdef DMEM_BYTE_WRITE_EN
        txn(1'b1, 32'h40, 32'h1122_3344, 4'hF, g_rd, g_err, g_lat, e_rd, e_err, e_chk);
        txn(1'b1, 32'h40, 32'hAABB_CCDD, 4'b0101, g_rd, g_err, g_lat, e_rd, e_err, e_chk);
        txn(1'b0, 32'h40, 32'h0, 4'hF, g_rd, g_err, g_lat, e_rd, e_err, e_chk);
        chk("be_merge", g_rd, 32'h11BB_33DD);
        txn(1'b1, 32'h40, 32'hFFFF_FFFF, 4'b0000, g_rd, g_err, g_lat, e_rd, e_err, e_chk);
        chk("be_zero_err", 32'(g_err), 32'd0);
        txn(1'b0, 32'h40, 32'h0, 4'hF, g_rd, g_err, g_lat, e_rd, e_err, e_chk);
        chk("be_zero_nochg", g_rd, 32'h11BB_33DD);
        txn(1'b1, MB + 32'd8, 32'h7777_7777, 4'b0011, g_rd, g_err, g_lat, e_rd, e_err, e_chk);
        chk("be_mmio_err", 32'(g_err), 32'd1);
        txn(1'b0, MB + 32'd8, 32'h0, 4'hF, g_rd, g_err, g_lat, e_rd, e_err, e_chk);
        chk("be_mmio_nochg", g_rd, m_scr);
`endif

        for (int i = 0; i < 64; i++) begin
            txn(1'b1, 32'(i) * 32'd4, $urandom, 4'hF, g_rd, g_err, g_lat, e_rd, e_err, e_chk);
        end

        for (int n = 0; n < 200; n++) begin
            k = int'($urandom_range(0, 9));
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            b = 4'hF;
`ifdef DMEM_BYTE_WRITE_EN
            b = 4'($urandom_range(0, 15));
`endif
            a = 32'($urandom_range(0, 63)) * 32'd4;
            case (k)
                5:       a = a + 32'($urandom_range(1, 3));
                6:       a = MB;
                7:       a = MB + 32'd4;
                8:       a = MB + 32'd8;
                9:       a = bad_list[$urandom_range(0, 3)];
                default: ;
            endcase
            txn(w, a, d, b, g_rd, g_err, g_lat, e_rd, e_err, e_chk);
            chk($sformatf("rnd%0d_err a=%h", n, a), 32'(g_err), 32'(e_err));
            chk($sformatf("rnd%0d_lat", n), 32'(g_lat), 32'd2);
            if (e_chk) chk($sformatf("rnd%0d_rdata a=%h", n, a), g_rd, e_rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-side memory responder on the processor's load/store bus: the target end of the address / write-data / write-enable / read-data interface.
- Accepts one request at a time over a req/ready handshake and inserts a configurable number of wait states.
- Decodes each request to word RAM, a small MMIO register bank, or an error response.
- Sits between the CPU data port (through a bus adapter) and on-chip RAM / board LEDs.

Parameters:
- DEPTH_WORDS, 1024, RAM depth in 32-bit words; byte range 0 .. 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 1, wait states between acceptance and response (0..15).
- MMIO_BASE, 32'h0001_0000, byte base address of the MMIO bank.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  1  request valid; held high until ready.
- we  in  1  1 = write, 0 = read; qualified by req.
- addr  in  32  byte address.
- wdata  in  32  write data.
- rdata  out  32  read data; valid only while ready=1.
- ready  out  1  one-cycle completion pulse.
- err  out  1  error flag; valid only while ready=1.
- led  out  32  LED register contents.

Behaviour:
- Reset and power-up:
  - rst is sampled on the rising clk edge. It drives the FSM to IDLE, ready=0, err=0, rdata=0, led=0 and cycle counter=0.
  - RAM contents are not reset.
  - Reset asserted mid-transaction aborts it: no write commits and no ready is issued.
- FSM IDLE:
  - When req=1, latch addr, we and wdata, and load wait counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, else go to RESP.
  - req is sampled only in IDLE.
- FSM WAIT:
  - Decrement the counter each cycle; go to RESP when it reaches 1.
  - Changes on the request inputs are ignored; the latched values are used.
  - req dropping early is a protocol violation; the transaction still completes.
- FSM RESP:
  - ready=1 for exactly one cycle, then return to IDLE.
  - Writes commit on the RESP clock edge.
  - rdata and err are driven registered during RESP.
- Latency and throughput:
  - ready rises WAIT_CYCLES+1 cycles after the cycle req was accepted.
  - Minimum one IDLE cycle between transactions.
  - The initiator may keep req high after ready; the next request is accepted in the following IDLE cycle.
- Address decode (latched address):
  - RAM: addr < 4*DEPTH_WORDS; word index addr[..:2].
  - MMIO, relative to MMIO_BASE:
    - +0x0: LED register, RW, drives led.
    - +0x4: cycle counter, RO; writes are ignored with err=0.
    - +0x8: scratch register, RW, reset 0.
  - Any other address gives err=1, rdata=32'hDEAD_BEEF, and no state change.
  - Misaligned access (addr[1:0]!=0) gives err=1 and rdata=0; a misaligned write does not commit.
- Cycle counter: 32-bit, increments every cycle outside reset, wraps 32'hFFFF_FFFF -> 0. A read returns its value at the RESP cycle.
- Read of a write-only slot does not apply; all readable slots return current contents.
- A read issued immediately after a write to the same address returns the new data.

Optional Feature:
- Macro DMEM_BYTE_WRITE_EN.
- Defined:
  - Adds input port be[3:0] (byte strobes), latched with the request.
  - RAM writes update only the bytes with be[i]=1.
  - be=4'b0000 completes with err=0 and no change.
  - MMIO writes require be=4'b1111, else err=1 and no write.
- Undefined: no be port; every write is a full 32-bit word.

Test Plan:
- Reset: hold rst 2 cycles, then release -> ready=0, err=0, led=0, rdata=0; counter reads 0 + elapsed cycles.
- RAM write/read, WAIT_CYCLES=1:
  - write 32'hCAFE_F00D to 0x0000_0010 -> ready 2 cycles after acceptance, err=0.
  - read same address -> rdata=32'hCAFE_F00D.
- MMIO:
  - write 32'h0000_00A5 to 0x0001_0000 -> led=32'hA5 from the cycle after RESP.
  - write to 0x0001_0004 -> err=0 and counter unaffected.
- Errors:
  - read 0x0002_0000 -> err=1, rdata=32'hDEAD_BEEF.
  - write 0x0000_0013 -> err=1, RAM word 4 unchanged.
- Reset mid-operation: assert rst during WAIT of a write to 0x20 -> no ready, word 8 retains its prior value, FSM back in IDLE.
- Byte strobes (DMEM_BYTE_WRITE_EN defined): word = 32'h1122_3344, write 32'hAABB_CCDD with be=4'b0101 -> read 32'h11BB_33DD.
